display_scan_timer: RTL

//  Raster timing generator for the video output path. Scans the display and

---
 rtl/display_scan_timer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/display_scan_timer.sv
// Raster timing generator: h/v counters, sync/blank/visible flags, raw scan position
// and offset-adjusted scroll coordinates for the tile fetch stage.
module display_scan_timer #(
    parameter int unsigned COORD_WIDTH = 10,
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33
) (
    input  logic                   clk,
    input  logic                   _reset,
    input  logic                   enable,
    input  logic [COORD_WIDTH-1:0] x_offset,
    input  logic [COORD_WIDTH-1:0] y_offset,
    output logic [COORD_WIDTH-1:0] x_pos,
    output logic [COORD_WIDTH-1:0] y_pos,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic                   visible,
    output logic [COORD_WIDTH-1:0] scroll_x,
    output logic [COORD_WIDTH-1:0] scroll_y,
    output logic                   line_start,
    output logic                   frame_start
);

    localparam int unsigned CW       = COORD_WIDTH;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Counters must be able to reach TOTAL-1 within CW bits.
    generate
        if (64'(H_TOTAL) > (64'd1 << CW)) begin : g_bad_h_total
            $error("display_scan_timer: H_TOTAL does not fit in COORD_WIDTH");
        end
        if (64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_v_total
            $error("display_scan_timer: V_TOTAL does not fit in COORD_WIDTH");
        end
    endgenerate

    logic          en_m, en_s;
    logic [CW-1:0] xo_m, xo_s, yo_m, yo_s;
    logic [CW-1:0] lat_x, lat_y;
    logic [CW-1:0] h_cnt, v_cnt;

    logic [CW-1:0] h_nxt, v_nxt;
    logic [CW-1:0] lat_x_nxt, lat_y_nxt;
    logic [CW-1:0] x_nxt, y_nxt;
    logic          at_origin;
    logic          load_lat;
    logic          h_sync_nxt, v_sync_nxt, visible_nxt;

    // Next counter state, offset latch and output values.
    always_comb begin
        h_nxt       = '0;
        v_nxt       = '0;
        at_origin   = (h_cnt == '0) && (v_cnt == '0);
        // Latch is transparent while disabled so the first frame after enable
        // already sees the current offsets.
        load_lat    = !en_s || at_origin;
        lat_x_nxt   = load_lat ? xo_s : lat_x;
        lat_y_nxt   = load_lat ? yo_s : lat_y;
        x_nxt       = en_s ? h_cnt : '0;
        y_nxt       = en_s ? v_cnt : '0;
        h_sync_nxt  = !(en_s && (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END));
        v_sync_nxt  = !(en_s && (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END));
        visible_nxt = en_s && (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
        if (en_s) begin
            if (32'(h_cnt) == H_TOTAL - 1) begin
                h_nxt = '0;
                v_nxt = (32'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + CW'(1);
            end else begin
                h_nxt = h_cnt + CW'(1);
                v_nxt = v_cnt;
            end
        end
    end

    // Synchronizers, counters, latch and registered outputs.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            en_m        <= 1'b0;
            en_s        <= 1'b0;
            xo_m        <= '0;
            xo_s        <= '0;
            yo_m        <= '0;
            yo_s        <= '0;
            lat_x       <= '0;
            lat_y       <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            visible     <= 1'b0;
            scroll_x    <= '0;
            scroll_y    <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            en_m        <= enable;
            en_s        <= en_m;
            xo_m        <= x_offset;
            xo_s        <= xo_m;
            yo_m        <= y_offset;
            yo_s        <= yo_m;
            lat_x       <= lat_x_nxt;
            lat_y       <= lat_y_nxt;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            x_pos       <= x_nxt;
            y_pos       <= y_nxt;
            h_sync      <= h_sync_nxt;
            v_sync      <= v_sync_nxt;
            visible     <= visible_nxt;
            scroll_x    <= x_nxt + lat_x_nxt;
            scroll_y    <= y_nxt + lat_y_nxt;
            line_start  <= en_s && (h_cnt == '0);
            frame_start <= en_s && at_origin;
        end
    end

endmodule
